// File: rtl/instruction_cache_controller.sv
// Direct-mapped 8-line instruction cache with a single-block fill sequencer,
// deferred line flush and saturating hit/miss counters.
module instruction_cache_controller (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CPU_READ,
    input  logic [31:0]  CPU_ADDRESS,
    output logic [31:0]  CPU_READDATA,
    output logic         CPU_BUSYWAIT,
    input  logic         FLUSH,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT,
    output logic [15:0]  HIT_COUNT,
    output logic [15:0]  MISS_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_READ,
        S_UPDATE
    } state_t;

    state_t       state;
    logic [7:0]   valid;
    logic [24:0]  tags [8];
    logic [127:0] data [8];
    logic         flush_pending;
    logic         fill_done;

    logic [2:0]   index;
    logic [1:0]   offset;
    logic [24:0]  tag;
    logic         hit;
    logic         unused_addr_bits;

    assign index            = CPU_ADDRESS[6:4];
    assign offset           = CPU_ADDRESS[3:2];
    assign tag              = CPU_ADDRESS[31:7];
    assign unused_addr_bits = ^CPU_ADDRESS[1:0];

    assign hit          = valid[index] && (tags[index] == tag);
    assign CPU_READDATA = data[index][{offset, 5'd0} +: 32];

    always_comb begin
        CPU_BUSYWAIT = 1'b1;
        if (state == S_IDLE)
            CPU_BUSYWAIT = CPU_READ && !hit;
    end

    // Tag/data arrays carry no reset; a reset landing on UPDATE must not install the line.
    always_ff @(posedge CLK) begin
        if (!RESET && state == S_UPDATE) begin
            data[MEM_ADDRESS[2:0]] <= MEM_READDATA;
            tags[MEM_ADDRESS[2:0]] <= MEM_ADDRESS[27:3];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= S_IDLE;
            valid         <= '0;
            flush_pending <= 1'b0;
            fill_done     <= 1'b0;
            MEM_READ      <= 1'b0;
            MEM_ADDRESS   <= '0;
            HIT_COUNT     <= '0;
            MISS_COUNT    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    fill_done     <= 1'b0;
                    flush_pending <= 1'b0;
                    if (FLUSH || flush_pending)
                        valid <= '0;
                    // The access that completes a fill was already counted as a miss.
                    if (CPU_READ && hit && !fill_done && HIT_COUNT != '1)
                        HIT_COUNT <= HIT_COUNT + 16'd1;
                    if (CPU_READ && !hit) begin
                        state       <= S_MEM_READ;
                        MEM_READ    <= 1'b1;
                        MEM_ADDRESS <= CPU_ADDRESS[31:4];
                        if (MISS_COUNT != '1)
                            MISS_COUNT <= MISS_COUNT + 16'd1;
                    end
                end
                S_MEM_READ: begin
                    if (FLUSH)
                        flush_pending <= 1'b1;
                    if (!MEM_BUSYWAIT) begin
                        state    <= S_UPDATE;
                        MEM_READ <= 1'b0;
                    end
                end
                S_UPDATE: begin
                    if (FLUSH)
                        flush_pending <= 1'b1;
                    valid[MEM_ADDRESS[2:0]] <= 1'b1;
                    fill_done               <= 1'b1;
                    state                   <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    MEM_READ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Directed bench for instruction_cache_controller with a fixed-latency block
// memory whose byte n of block B reads as {B[3:0], n[3:0]}.
module tb_instruction_cache_controller;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         CPU_READ;
    logic [31:0]  CPU_ADDRESS;
    logic [31:0]  CPU_READDATA;
    logic         CPU_BUSYWAIT;
    logic         FLUSH;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
    logic [15:0]  HIT_COUNT;
    logic [15:0]  MISS_COUNT;

    int checks = 0;
    int errors = 0;
    int lat    = 4;
    int mcnt   = 0;

    instruction_cache_controller dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CPU_READ     (CPU_READ),
        .CPU_ADDRESS  (CPU_ADDRESS),
        .CPU_READDATA (CPU_READDATA),
        .CPU_BUSYWAIT (CPU_BUSYWAIT),
        .FLUSH        (FLUSH),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT),
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
    );

    always #5 CLK = ~CLK;

    // Memory: busy while READ is high until the lat-th edge in the read.
    always @(posedge CLK) begin
        if (!MEM_READ) mcnt <= 0;
        else           mcnt <= mcnt + 1;
    end
    assign MEM_BUSYWAIT = MEM_READ && (mcnt < lat - 1);

    always_comb begin
        MEM_READDATA = '0;
        for (int n = 0; n < 16; n++)
            MEM_READDATA[8*n +: 8] = {MEM_ADDRESS[3:0], 4'(n)};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one fetch; n is the cycle (1-based) in which CPU_BUSYWAIT was low.
    task automatic fetch(input logic [31:0] a, output int n, output logic [31:0] d);
        CPU_READ    = 1'b1;
        CPU_ADDRESS = a;
        n = 0;
        d = 'x;
        while (n < 50) begin
            @(negedge CLK);
            n++;
            if (!CPU_BUSYWAIT) begin
                d = CPU_READDATA;
                break;
            end
        end
        @(posedge CLK);
        #1;
        CPU_READ = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] d;

        RESET = 1'b0; CPU_READ = 1'b0; CPU_ADDRESS = '0; FLUSH = 1'b0;
        @(posedge CLK); #1;
        do_reset();

        // Reset state
        check("rst_hit",     32'(HIT_COUNT), 32'h0);
        check("rst_miss",    32'(MISS_COUNT), 32'h0);
        check("rst_memread", 32'(MEM_READ), 32'h0);
        check("rst_memaddr", 32'(MEM_ADDRESS), 32'h0);
        check("rst_busy_idle", 32'(CPU_BUSYWAIT), 32'h0);
        CPU_READ = 1'b1; CPU_ADDRESS = 32'h10;
        #1;
        check("rst_busy_read", 32'(CPU_BUSYWAIT), 32'h1);

        // First miss, latency 4
        fetch(32'h10, n, d);
        check("miss_cycles", 32'(n), 32'd7);
        check("miss_data", d, 32'h13121110);
        check("miss_memaddr", 32'(MEM_ADDRESS), 32'h0000001);
        check("miss_cnt1", 32'(MISS_COUNT), 32'd1);
        check("hit_cnt0", 32'(HIT_COUNT), 32'd0);

        // Sequential hits in the same block
        fetch(32'h14, n, d);
        check("seq14_cycles", 32'(n), 32'd1);
        check("seq14_data", d, 32'h17161514);
        fetch(32'h18, n, d);
        check("seq18_cycles", 32'(n), 32'd1);
        check("seq18_data", d, 32'h1B1A1918);
        fetch(32'h1C, n, d);
        check("seq1c_cycles", 32'(n), 32'd1);
        check("seq1c_data", d, 32'h1F1E1D1C);
        check("seq_hit_cnt", 32'(HIT_COUNT), 32'd3);
        check("seq_miss_cnt", 32'(MISS_COUNT), 32'd1);

        // Conflict on index 0
        fetch(32'h00, n, d);
        check("conf0_cycles", 32'(n), 32'd7);
        check("conf0_addr", 32'(MEM_ADDRESS), 32'h0);
        check("conf0_data", d, 32'h03020100);
        fetch(32'h80, n, d);
        check("conf80_cycles", 32'(n), 32'd7);
        check("conf80_addr", 32'(MEM_ADDRESS), 32'h8);
        check("conf80_data", d, 32'h83828180);
        fetch(32'h00, n, d);
        check("conf0b_cycles", 32'(n), 32'd7);
        check("conf0b_addr", 32'(MEM_ADDRESS), 32'h0);
        check("conf0b_data", d, 32'h03020100);
        check("conf_miss_cnt", 32'(MISS_COUNT), 32'd4);
        check("conf_hit_cnt", 32'(HIT_COUNT), 32'd3);

        // FLUSH during MEM_READ: fill completes, line gone afterwards
        do_reset();
        fork
            fetch(32'h20, n, d);
            begin
                @(posedge CLK); #1;
                FLUSH = 1'b1;
                @(posedge CLK); #1;
                FLUSH = 1'b0;
            end
        join
        check("flush_cycles", 32'(n), 32'd7);
        check("flush_data", d, 32'h23222120);
        fetch(32'h20, n, d);
        check("flush_refetch_cycles", 32'(n), 32'd7);
        check("flush_miss_cnt", 32'(MISS_COUNT), 32'd2);
        check("flush_hit_cnt", 32'(HIT_COUNT), 32'd0);

        // RESET while in MEM_READ abandons the fill
        do_reset();
        CPU_READ = 1'b1; CPU_ADDRESS = 32'h30;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rstfill_memread_on", 32'(MEM_READ), 32'h1);
        RESET = 1'b1; CPU_READ = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rstfill_memread_off", 32'(MEM_READ), 32'h0);
        check("rstfill_miss_cnt", 32'(MISS_COUNT), 32'd0);
        check("rstfill_hit_cnt", 32'(HIT_COUNT), 32'd0);
        @(posedge CLK); #1;
        fetch(32'h30, n, d);
        check("rstfill_refetch_cycles", 32'(n), 32'd7);
        check("rstfill_refetch_data", d, 32'h33323130);
        check("rstfill_refetch_miss", 32'(MISS_COUNT), 32'd1);

        // Hit counter saturation
        do_reset();
        fetch(32'h10, n, d);
        CPU_READ = 1'b1; CPU_ADDRESS = 32'h10;
        repeat (65534) @(posedge CLK);
        #1;
        check("sat_fffe", 32'(HIT_COUNT), 32'hFFFE);
        check("sat_busy", 32'(CPU_BUSYWAIT), 32'h0);
        @(posedge CLK); #1;
        check("sat_ffff_1", 32'(HIT_COUNT), 32'hFFFF);
        @(posedge CLK); #1;
        check("sat_ffff_2", 32'(HIT_COUNT), 32'hFFFF);
        @(posedge CLK); #1;
        check("sat_ffff_3", 32'(HIT_COUNT), 32'hFFFF);
        check("sat_miss_cnt", 32'(MISS_COUNT), 32'd1);
        CPU_READ = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_cache_controller.md
# instruction_cache_controller

Direct-mapped instruction cache and fill sequencer sitting between the CPU fetch stage and the 128-bit block instruction memory. It serves 32-bit instruction reads from eight 128-bit lines. On a miss it drives the memory's READ/BUSYWAIT handshake to fetch the full block, installs it, and releases the fetch stage. It also provides a line flush and saturating hit/miss counters for performance monitoring.

## Interface
- No parameters: 8 lines, 16-byte blocks, 25-bit tags, fixed.
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- CPU_READ  input  1  fetch request, held high until CPU_BUSYWAIT is low at a rising edge.
- CPU_ADDRESS  input  32  byte address; [1:0] ignored, [3:2] word offset, [6:4] index, [31:7] tag.
- CPU_READDATA  output  32  instruction; valid when CPU_READ=1 and CPU_BUSYWAIT=0.
- CPU_BUSYWAIT  output  1  stall to the fetch stage.
- FLUSH  input  1  single-cycle pulse that invalidates all lines.
- MEM_READ  output  1  block read request to instruction memory.
- MEM_ADDRESS  output  28  block address, equal to CPU_ADDRESS[31:4] of the missing fetch.
- MEM_READDATA  input  128  fetched block; byte n of the block is at [8n+7:8n].
- MEM_BUSYWAIT  input  1  memory busy; it rises combinationally with MEM_READ and falls when the block is available.
- HIT_COUNT  output  16  saturating hit counter.
- MISS_COUNT  output  16  saturating miss counter.

## Operation
- Storage per line: valid bit, 25-bit tag, 128-bit data. Word w of a line is data[32w+31:32w].
- hit = valid[index] && tag[index] == CPU_ADDRESS[31:7]. This is combinational.
- CPU_READDATA = word CPU_ADDRESS[3:2] of line CPU_ADDRESS[6:4]. It is combinational and is don't-care while stalled.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE, with CPU_READ=1 and a miss: go to MEM_READ and register MEM_ADDRESS from CPU_ADDRESS[31:4].
- IDLE, any other case: stay in IDLE.
- MEM_READ: MEM_READ=1. Move to UPDATE at the first rising edge where MEM_BUSYWAIT=0, not counting the edge that entered the state.
- UPDATE: MEM_READ=0. Write MEM_READDATA into the data array, write MEM_ADDRESS[27:3] into the tag array, and set the valid bit for index MEM_ADDRESS[2:0]. Go to IDLE.
- CPU_BUSYWAIT is combinational:
  - IDLE: CPU_READ && !hit.
  - MEM_READ and UPDATE: 1.
- Block data is captured from MEM_READDATA at the UPDATE edge. The memory holds READDATA stable after BUSYWAIT falls.
- FLUSH:
  - In IDLE: clears every valid bit at that edge.
  - In MEM_READ or UPDATE: sets flush_pending. The fill still completes, then all valid bits, including the just-filled line, are cleared on the first IDLE edge, and flush_pending clears.
  - Pending flushes do not stack.
- Counters (saturate at 16'hFFFF, never wrap):
  - MISS_COUNT increments on each IDLE→MEM_READ transition.
  - HIT_COUNT increments on each IDLE edge with CPU_READ && hit, except the first IDLE edge after UPDATE. That access completes the miss already counted.
- CPU_ADDRESS must stay stable while CPU_BUSYWAIT=1. The block does not re-check it mid-fill.

## Timing
- Reset values after an edge with RESET=1:
  - state IDLE, all valid bits 0, flush_pending 0.
  - MEM_READ 0, MEM_ADDRESS 0, HIT_COUNT 0, MISS_COUNT 0.
  - CPU_BUSYWAIT equals CPU_READ, since every access then misses.
- Tag and data arrays are not reset.
- RESET mid-fill (MEM_READ or UPDATE): abandon the fill, write nothing, drop MEM_READ next cycle. The memory clears its BUSYWAIT when READ falls.
- Hit latency: 0 cycles. CPU_BUSYWAIT stays low and data is available in the same cycle.
- Miss: CPU_BUSYWAIT is high for 1 (IDLE detect) + N (MEM_READ, N ≥ 1 is the number of edges until MEM_BUSYWAIT=0) + 1 (UPDATE) cycles. It falls in the first IDLE cycle after UPDATE.
- Back-to-back misses: one dead IDLE cycle occurs between UPDATE and the next MEM_READ.
- MEM_READ is never asserted outside the MEM_READ state. It is registered from the state and glitch-free.
- RESET has priority over FLUSH. FLUSH in the same cycle as an IDLE miss clears valid bits and still starts the fill.

## Test plan
- Reset, then CPU_READ=1 at 0x00000010: CPU_BUSYWAIT=1 and MEM_ADDRESS=28'h0000001. With memory latency 4 edges, CPU_BUSYWAIT falls in cycle 7 and the word equals bytes 0x13..0x10. MISS_COUNT=1, HIT_COUNT=0.
- Sequential fetch 0x10, 0x14, 0x18, 0x1C: one miss, then three zero-stall hits. HIT_COUNT=3, MISS_COUNT=1.
- Conflict: 0x00000000, then 0x00000080 (same index, different tag), then 0x00000000 again: three misses. MEM_ADDRESS is 0x0000000, 0x0000008, 0x0000000.
- FLUSH pulse during MEM_READ for 0x20: the fill completes and CPU_BUSYWAIT falls once. A re-fetch of 0x20 misses again, giving MISS_COUNT=2.
- RESET asserted in MEM_READ: MEM_READ=0 the next cycle, counters are 0, and the next fetch to the same address misses.
- Force HIT_COUNT to 16'hFFFE, then three hits: the counter reads FFFF and holds.
